// File: rtl/fixed_nr_iter_ctrl_if.sv
// Handshake bundle around the rsqrt NR iteration controller: job input, stage
// issue/return and final output. The controller takes the master view.
interface fixed_nr_iter_ctrl_if #(
  parameter int WIDTH     = 16,
  parameter int MSB_WIDTH = 1
);
  logic [WIDTH-1:0]     data_in_x_reduced;
  logic [WIDTH-1:0]     data_in_lut;
  logic [MSB_WIDTH-1:0] data_in_msb;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [WIDTH-1:0]     nr_data_a;
  logic [WIDTH-1:0]     nr_data_b;
  logic [MSB_WIDTH-1:0] nr_data_msb;
  logic                 nr_valid;
  logic                 nr_ready;
  logic [2*WIDTH-1:0]   nr_result;
  logic [MSB_WIDTH-1:0] nr_result_msb;
  logic                 nr_result_valid;
  logic                 nr_result_ready;
  logic [WIDTH-1:0]     data_out;
  logic [WIDTH-1:0]     data_out_x_reduced;
  logic [MSB_WIDTH-1:0] data_out_msb;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic                 busy;

  modport master (
    input  data_in_x_reduced, data_in_lut, data_in_msb, data_in_valid,
    output data_in_ready,
    output nr_data_a, nr_data_b, nr_data_msb, nr_valid,
    input  nr_ready,
    input  nr_result, nr_result_msb, nr_result_valid,
    output nr_result_ready,
    output data_out, data_out_x_reduced, data_out_msb, data_out_valid,
    input  data_out_ready,
    output busy
  );

  modport slave (
    output data_in_x_reduced, data_in_lut, data_in_msb, data_in_valid,
    input  data_in_ready,
    input  nr_data_a, nr_data_b, nr_data_msb, nr_valid,
    output nr_ready,
    output nr_result, nr_result_msb, nr_result_valid,
    input  nr_result_ready,
    input  data_out, data_out_x_reduced, data_out_msb, data_out_valid,
    output data_out_ready,
    input  busy
  );
endinterface

// File: rtl/fixed_nr_iter_ctrl.sv
// Iteration sequencer for one rsqrt Newton-Raphson stage: takes one job, loops the
// saturated stage result back as the next seed NUM_ITER times, then presents it.
module fixed_nr_iter_ctrl #(
  parameter int WIDTH     = 16,
  parameter int MSB_WIDTH = 1,
  parameter int NUM_ITER  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fixed_nr_iter_ctrl_if.master  bus
);
  localparam int IW = (NUM_ITER > 0) ? $clog2(NUM_ITER + 1) : 1;
  localparam logic [IW-1:0] LAST_ITER = IW'((NUM_ITER > 0) ? NUM_ITER - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_y;
  logic [MSB_WIDTH-1:0] r_msb;
  logic [IW-1:0]        r_iter;
  logic                 r_in_ready;
  logic                 r_nr_valid;
  logic                 r_res_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [WIDTH-1:0]     w_sat;
  logic                 w_unused;

  // Stage output is 2W wide; anything above Q1.(W-1) range clamps to all-ones.
  function automatic logic [WIDTH-1:0] sat_q(input logic [2*WIDTH-1:0] r);
    if (|r[2*WIDTH-1:WIDTH]) begin
      sat_q = {WIDTH{1'b1}};
    end else begin
      sat_q = r[WIDTH-1:0];
    end
  endfunction

  assign w_sat    = sat_q(bus.nr_result);
  assign w_unused = ^bus.nr_result_msb;

  // Control FSM with registered handshake outputs and job registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_x         <= {WIDTH{1'b0}};
      r_y         <= {WIDTH{1'b0}};
      r_msb       <= {MSB_WIDTH{1'b0}};
      r_iter      <= {IW{1'b0}};
      r_in_ready  <= 1'b1;
      r_nr_valid  <= 1'b0;
      r_res_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.data_in_valid && r_in_ready) begin
            r_x        <= bus.data_in_x_reduced;
            r_y        <= bus.data_in_lut;
            r_msb      <= bus.data_in_msb;
            r_iter     <= {IW{1'b0}};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (NUM_ITER == 0) begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_nr_valid <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (bus.nr_ready) begin
            r_state     <= S_WAIT;
            r_nr_valid  <= 1'b0;
            r_res_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.nr_result_valid) begin
            r_y         <= w_sat;
            r_iter      <= r_iter + IW'(1);
            r_res_ready <= 1'b0;
            if (r_iter == LAST_ITER) begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= S_ISSUE;
              r_nr_valid <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (bus.data_out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_nr_valid  <= 1'b0;
          r_res_ready <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Handshakes are forced low for the whole time reset is held, not just after the edge.
  assign bus.data_in_ready      = r_in_ready  & ~i_rst;
  assign bus.nr_valid           = r_nr_valid  & ~i_rst;
  assign bus.nr_result_ready    = r_res_ready & ~i_rst;
  assign bus.data_out_valid     = r_out_valid & ~i_rst;
  assign bus.busy               = r_busy      & ~i_rst;
  assign bus.nr_data_a          = r_x;
  assign bus.nr_data_b          = r_y;
  assign bus.nr_data_msb        = r_msb;
  assign bus.data_out           = r_y;
  assign bus.data_out_x_reduced = r_x;
  assign bus.data_out_msb       = r_msb;
endmodule

// File: tb/tb_fixed_nr_iter_ctrl.sv
// Directed bench for the NR iteration controller: a behavioural rsqrt stage with
// optional random handshakes, a scoreboard of expected results, and a bypass instance.
module tb_fixed_nr_iter_ctrl;
  localparam int W  = 16;
  localparam int MW = 1;
  localparam int LS = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fixed_nr_iter_ctrl_if #(.WIDTH(W), .MSB_WIDTH(MW)) bus  ();
  fixed_nr_iter_ctrl_if #(.WIDTH(W), .MSB_WIDTH(MW)) bus0 ();

  fixed_nr_iter_ctrl #(.WIDTH(W), .MSB_WIDTH(MW), .NUM_ITER(2)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  fixed_nr_iter_ctrl #(.WIDTH(W), .MSB_WIDTH(MW), .NUM_ITER(0)) u_dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  // One rsqrt NR step in Q1.15: y * (3 - x*y*y) / 2, unsaturated, 2W wide.
  function automatic logic [31:0] nr_step(input logic [15:0] x, input logic [15:0] y);
    logic [63:0] xyy, t, r;
    xyy = (64'(x) * 64'(y) * 64'(y)) >> 30;
    t   = (xyy >= 64'h18000) ? 64'd0 : (64'h18000 - xyy);
    r   = (64'(y) * t) >> 16;
    return r[31:0];
  endfunction

  function automatic logic [15:0] golden(input logic [15:0] x, input logic [15:0] y0);
    logic [15:0] y;
    logic [31:0] r;
    y = y0;
    for (int k = 0; k < 2; k++) begin
      r = nr_step(x, y);
      y = (r[31:16] != 16'd0) ? 16'hFFFF : r[15:0];
    end
    return y;
  endfunction

  // Behavioural stage with latency LS and optional random ready/valid.
  logic        stg_busy, stg_done, rnd_rdy, rnd_vld, rnd_en;
  int          stg_cnt;
  int          issue_cnt = 0;
  logic [31:0] stg_res;

  always @(posedge clk) begin
    if (rst) begin
      stg_busy <= 1'b0;
      stg_done <= 1'b0;
      stg_cnt  <= 0;
      stg_res  <= 32'd0;
      rnd_rdy  <= 1'b1;
      rnd_vld  <= 1'b1;
    end else begin
      rnd_rdy <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      rnd_vld <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!stg_busy && bus.nr_valid && bus.nr_ready) begin
        stg_busy  <= 1'b1;
        stg_done  <= 1'b0;
        stg_cnt   <= LS;
        stg_res   <= nr_step(bus.nr_data_a, bus.nr_data_b);
        issue_cnt <= issue_cnt + 1;
      end else if (stg_busy && !stg_done) begin
        if (stg_cnt <= 1) stg_done <= 1'b1;
        else stg_cnt <= stg_cnt - 1;
      end else if (stg_done && bus.nr_result_valid && bus.nr_result_ready) begin
        stg_busy <= 1'b0;
        stg_done <= 1'b0;
      end
    end
  end

  assign bus.nr_ready         = !stg_busy && rnd_rdy;
  assign bus.nr_result_valid  = stg_done && rnd_vld;
  assign bus.nr_result        = stg_res;
  assign bus.nr_result_msb    = {MW{1'b0}};
  assign bus0.nr_ready        = 1'b1;
  assign bus0.nr_result       = 32'd0;
  assign bus0.nr_result_msb   = {MW{1'b0}};
  assign bus0.nr_result_valid = 1'b0;

  logic nr0_seen = 1'b0;
  logic out_seen = 1'b0;
  always @(posedge clk) begin
    if (bus0.nr_valid) nr0_seen <= 1'b1;
    if (bus.data_out_valid) out_seen <= 1'b1;
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [0:0]  msb;
  } exp_t;
  exp_t sb[$];
  int   issue_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_job(input logic [15:0] x, input logic [15:0] y, input logic m);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.data_in_x_reduced = x;
    bus.data_in_lut       = y;
    bus.data_in_msb       = m;
    bus.data_in_valid     = 1'b1;
    n = 0;
    while (bus.data_in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready", 32'(bus.data_in_ready), 32'd1);
    issue_base = issue_cnt;
    e.x = x;
    e.y = golden(x, y);
    e.msb = m;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.data_in_valid = 1'b0;
  endtask

  task automatic recv_job(input string tag);
    exp_t e;
    int   n;
    bus.data_out_ready = 1'b1;
    n = 0;
    while (bus.data_out_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus.data_out_valid), 32'd1);
    e = sb.pop_front();
    check({tag, "_y"}, 32'(bus.data_out), 32'(e.y));
    check({tag, "_x"}, 32'(bus.data_out_x_reduced), 32'(e.x));
    check({tag, "_msb"}, 32'(bus.data_out_msb), 32'(e.msb));
    @(posedge clk);
    #1 bus.data_out_ready = 1'b0;
    check({tag, "_issues"}, 32'(issue_cnt - issue_base), 32'd2);
  endtask

  initial begin
    logic [15:0] hy, hx;
    logic        hm;
    exp_t        e;
    int          n;
    rst = 1'b1;
    rnd_en = 1'b0;
    bus.data_in_x_reduced  = 16'd0;
    bus.data_in_lut        = 16'd0;
    bus.data_in_msb        = 1'b0;
    bus.data_in_valid      = 1'b0;
    bus.data_out_ready     = 1'b0;
    bus0.data_in_x_reduced = 16'd0;
    bus0.data_in_lut       = 16'd0;
    bus0.data_in_msb       = 1'b0;
    bus0.data_in_valid     = 1'b0;
    bus0.data_out_ready    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.data_in_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_nr_valid", 32'(bus.nr_valid), 32'd0);
    check("rst_out_valid", 32'(bus.data_out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.data_in_ready), 32'd1);
    check("idle_y", 32'(bus.data_out), 32'd0);
    check("idle_x", 32'(bus.nr_data_a), 32'd0);

    // Scenario 1: fixed point, then scenario 2: saturation on every pass
    send_job(16'h8000, 16'h8000, 1'b1);
    check("busy_job", 32'(bus.busy), 32'd1);
    recv_job("fixpt");
    send_job(16'h0000, 16'hFFFF, 1'b0);
    recv_job("sat");
    send_job(16'h4000, 16'hB000, 1'b1);
    recv_job("mid");

    // Scenario 3: bypass instance
    @(negedge clk);
    bus0.data_in_x_reduced = 16'h1234;
    bus0.data_in_lut       = 16'h5678;
    bus0.data_in_msb       = 1'b1;
    bus0.data_in_valid     = 1'b1;
    check("byp_in_ready", 32'(bus0.data_in_ready), 32'd1);
    @(posedge clk);
    #1 bus0.data_in_valid = 1'b0;
    check("byp_valid", 32'(bus0.data_out_valid), 32'd1);
    check("byp_y", 32'(bus0.data_out), 32'h5678);
    check("byp_x", 32'(bus0.data_out_x_reduced), 32'h1234);
    check("byp_msb", 32'(bus0.data_out_msb), 32'd1);
    check("byp_in_ready_out", 32'(bus0.data_in_ready), 32'd0);
    bus0.data_out_ready = 1'b1;
    @(posedge clk);
    #1 bus0.data_out_ready = 1'b0;
    check("byp_done", 32'(bus0.data_out_valid), 32'd0);
    check("byp_idle", 32'(bus0.data_in_ready), 32'd1);

    // Scenario 4: output backpressure for 10 cycles
    send_job(16'h2000, 16'hC000, 1'b1);
    n = 0;
    while (bus.data_out_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 32'(bus.data_out_valid), 32'd1);
    hy = bus.data_out;
    hx = bus.data_out_x_reduced;
    hm = bus.data_out_msb;
    e = sb.pop_front();
    check("bp_y", 32'(hy), 32'(e.y));
    check("bp_x", 32'(hx), 32'(e.x));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {bus.data_out, 7'd0, bus.data_out_msb, 7'd0, bus.data_out_valid},
            {hy, 7'd0, hm, 7'd0, 1'b1});
      check("bp_in_ready", 32'(bus.data_in_ready), 32'd0);
      check("bp_hold_x", 32'(bus.data_out_x_reduced), 32'(hx));
    end
    bus.data_out_ready = 1'b1;
    @(posedge clk);
    #1 bus.data_out_ready = 1'b0;
    check("bp_rel_ready", 32'(bus.data_in_ready), 32'd1);
    check("bp_rel_valid", 32'(bus.data_out_valid), 32'd0);
    check("bp_rel_busy", 32'(bus.busy), 32'd0);

    // Scenario 5: random stage handshakes
    rnd_en = 1'b1;
    send_job(16'h8000, 16'h8000, 1'b1);
    recv_job("rnd_fix");
    for (int j = 0; j < 4; j++) begin
      send_job(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)));
      recv_job("rnd");
    end
    rnd_en = 1'b0;

    // Scenario 6: reset while waiting on the stage
    send_job(16'h8000, 16'h9000, 1'b1);
    n = 0;
    while (bus.nr_result_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_wait", 32'(bus.nr_result_ready), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_rst_res_ready", 32'(bus.nr_result_ready), 32'd0);
    check("abort_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    #1;
    check("abort_idle_ready", 32'(bus.data_in_ready), 32'd1);
    check("abort_idle_busy", 32'(bus.busy), 32'd0);
    check("abort_nr_valid", 32'(bus.nr_valid), 32'd0);
    check("abort_res_ready", 32'(bus.nr_result_ready), 32'd0);
    out_seen = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_out", 32'(out_seen), 32'd0);
    send_job(16'h0000, 16'hFFFF, 1'b0);
    recv_job("post_rst");

    check("byp_never_issued", 32'(nr0_seen), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
